csr_intr_unit: RTL and testbench

Parametrised machine-mode CSR file and interrupt controller for the pipelined RV32 core. It replaces the fixed timer/external interrupt pair with NUM_EXT_IRQ external lines (per-line edge/level mode), adds a built-in prescaled 64-bit machine timer, and supports direct or vectored trap entry. The block sits in the memory stage: it performs CSR reads and writes, takes interrupts at instruction boundaries and supplies the redirect PC to the fetch-stage PC mux.

---
 rtl/csr_intr_unit.sv | 213 +++++++++++++++++++++
 tb/tb_csr_intr_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_intr_unit.sv
// Machine-mode CSR file and interrupt controller: external IRQ lines with
// per-line edge/level mode, prescaled 64-bit timer, direct/vectored trap entry.
module csr_intr_unit #(
   parameter int unsigned                NUM_EXT_IRQ = 4,
   parameter logic [NUM_EXT_IRQ-1:0]     EDGE_MASK   = '0,
   parameter int unsigned                PRESCALE    = 1,
   parameter logic [31:0]                MTVEC_RST   = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   csr_rd,
   input  logic                   csr_wr,
   input  logic [1:0]             csr_op,
   input  logic [11:0]            csr_addr,
   input  logic [31:0]            csr_wdata,
   output logic [31:0]            csr_rdata,
   input  logic [31:0]            pc_in,
   input  logic                   inst_valid,
   input  logic                   is_mret,
   input  logic [NUM_EXT_IRQ-1:0] ext_irq,
   output logic                   intr_flag,
   output logic [31:0]            epc,
   output logic                   t_intr
);

   localparam logic [11:0] A_MSTATUS     = 12'h300;
   localparam logic [11:0] A_MIE         = 12'h304;
   localparam logic [11:0] A_MTVEC       = 12'h305;
   localparam logic [11:0] A_MEPC        = 12'h341;
   localparam logic [11:0] A_MCAUSE      = 12'h342;
   localparam logic [11:0] A_MIP         = 12'h344;
   localparam logic [11:0] A_MTIME_LO    = 12'hC00;
   localparam logic [11:0] A_MTIME_HI    = 12'hC80;
   localparam logic [11:0] A_MTIMECMP_LO = 12'h7C0;
   localparam logic [11:0] A_MTIMECMP_HI = 12'h7C1;

   localparam int unsigned PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [31:0] MIE_MASK  = (((32'h1 << NUM_EXT_IRQ) - 32'h1) << 16) | 32'h80;

   typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET} state_t;

   state_t                 state;
   logic                   mstatus_mie, mstatus_mpie;
   logic [31:0]            mie_q, mtvec_q, mepc_q, mcause_q;
   logic [63:0]            mtime_q, mtimecmp_q, mtime_nxt, mtimecmp_nxt;
   logic [PW-1:0]          presc_q;
   logic                   presc_wrap;
   logic [NUM_EXT_IRQ-1:0] sync1, sync2, sync_prev, mip_ext, mip_ext_nxt;
   logic [NUM_EXT_IRQ-1:0] pend_ext, irq_onehot, edge_clr, csr_mip_clr, wd_ext;
   logic                   pend_tim, any_pend, found;
   logic [4:0]             irq_code;
   logic                   trap_take, ret_take, csr_we;
   logic [31:0]            rd_raw, wr_val, mip_word, mtvec_base;

   function automatic logic [31:0] csr_apply(input logic [31:0] old, input logic [1:0] op,
                                             input logic [31:0] wd);
      case (op)
         2'b00:   return wd;
         2'b01:   return old | wd;
         2'b10:   return old & ~wd;
         default: return old;
      endcase
   endfunction

   assign mip_word   = (32'(mip_ext) << 16) | {24'h0, t_intr, 7'h0};
   assign mtvec_base = {mtvec_q[31:2], 2'b00};
   assign pend_ext   = mip_ext & mie_q[16 +: NUM_EXT_IRQ];
   assign pend_tim   = t_intr & mie_q[7];
   assign any_pend   = (|pend_ext) | pend_tim;

   // Lowest-index external line wins; the timer only when no line is pending.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      irq_code   = 5'd7;
      irq_onehot = '0;
      found      = 1'b0;
      for (int i = 0; i < NUM_EXT_IRQ; i++) begin
         if (!found && pend_ext[i]) begin
            found         = 1'b1;
            irq_code      = 5'(16 + i);
            irq_onehot[i] = 1'b1;
         end
      end
   end

   assign trap_take = (state == S_IDLE) & inst_valid & mstatus_mie & any_pend & ~is_mret;
   assign ret_take  = (state == S_IDLE) & inst_valid & is_mret;
   assign csr_we    = csr_wr & ~trap_take;

   always_comb begin
      rd_raw = '0;
      case (csr_addr)
         A_MSTATUS:     rd_raw = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
         A_MIE:         rd_raw = mie_q;
         A_MTVEC:       rd_raw = mtvec_q;
         A_MEPC:        rd_raw = mepc_q;
         A_MCAUSE:      rd_raw = mcause_q;
         A_MIP:         rd_raw = mip_word;
         A_MTIME_LO:    rd_raw = mtime_q[31:0];
         A_MTIME_HI:    rd_raw = mtime_q[63:32];
         A_MTIMECMP_LO: rd_raw = mtimecmp_q[31:0];
         A_MTIMECMP_HI: rd_raw = mtimecmp_q[63:32];
         default:       rd_raw = '0;
      endcase
   end

   assign csr_rdata = csr_rd ? rd_raw : 32'h0;
   assign wr_val    = csr_apply(rd_raw, csr_op, csr_wdata);

   // Timer: next-state values feed the compare so t_intr tracks mtime/mtimecmp exactly.
   always_comb begin
      presc_wrap   = (presc_q == PRESC_MAX);
      mtime_nxt    = presc_wrap ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_nxt = mtimecmp_q;
      if (csr_we && csr_addr == A_MTIMECMP_LO) mtimecmp_nxt[31:0]  = wr_val;
      if (csr_we && csr_addr == A_MTIMECMP_HI) mtimecmp_nxt[63:32] = wr_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q    <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         t_intr     <= 1'b0;
      end else begin
         presc_q    <= presc_wrap ? '0 : presc_q + PW'(1);
         mtime_q    <= mtime_nxt;
         mtimecmp_q <= mtimecmp_nxt;
         t_intr     <= (mtime_nxt >= mtimecmp_nxt);
      end
   end

   // Edge latches accept clear-only CSR writes; a new edge beats any clear.
   always_comb begin
      wd_ext      = csr_wdata[16 +: NUM_EXT_IRQ];
      csr_mip_clr = '0;
      if (csr_we && csr_addr == A_MIP) begin
         if (csr_op == 2'b00)      csr_mip_clr = ~wd_ext;
         else if (csr_op == 2'b10) csr_mip_clr = wd_ext;
      end
      edge_clr    = csr_mip_clr | (trap_take ? irq_onehot : '0);
      mip_ext_nxt = (EDGE_MASK & ((sync2 & ~sync_prev) | (mip_ext & ~edge_clr)))
                  | (~EDGE_MASK & sync2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= '0;
         sync2     <= '0;
         sync_prev <= '0;
         mip_ext   <= '0;
      end else begin
         sync1     <= ext_irq;
         sync2     <= sync1;
         sync_prev <= sync2;
         mip_ext   <= mip_ext_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_q        <= '0;
         mtvec_q      <= MTVEC_RST;
         mepc_q       <= '0;
         mcause_q     <= '0;
         intr_flag    <= 1'b0;
         epc          <= '0;
      end else begin
         if (csr_we) begin
            case (csr_addr)
               A_MSTATUS: begin
                  mstatus_mie  <= wr_val[3];
                  mstatus_mpie <= wr_val[7];
               end
               A_MIE:    mie_q    <= wr_val & MIE_MASK;
               A_MTVEC:  mtvec_q  <= {wr_val[31:2], 1'b0, wr_val[1:0] == 2'b01};
               A_MEPC:   mepc_q   <= {wr_val[31:2], 2'b00};
               A_MCAUSE: mcause_q <= wr_val;
               default:  ;
            endcase
         end
         // NOTE: the FSM follows the CSR writes so its non-blocking updates to mstatus win.
         case (state)
            S_IDLE: begin
               if (ret_take) begin
                  state        <= S_RET;
                  intr_flag    <= 1'b1;
                  epc          <= mepc_q;
                  mstatus_mie  <= mstatus_mpie;
                  mstatus_mpie <= 1'b1;
               end else if (trap_take) begin
                  state        <= S_TRAP;
                  intr_flag    <= 1'b1;
                  epc          <= mtvec_q[0] ? mtvec_base + (32'(irq_code) << 2) : mtvec_base;
                  mepc_q       <= {pc_in[31:2], 2'b00};
                  mcause_q     <= {1'b1, 26'h0, irq_code};
                  mstatus_mpie <= mstatus_mie;
                  mstatus_mie  <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               intr_flag <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csr_intr_unit.sv
// Self-checking bench for csr_intr_unit: directed trap/mret sequences, a CSR
// op vector table and randomized CSR traffic against a register-level model.
module tb_csr_intr_unit;

   logic        clk, rst;
   logic        csr_rd, csr_wr;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, csr_rdata, pc_in, epc;
   logic        inst_valid, is_mret, intr_flag, t_intr;
   logic [3:0]  ext_irq;

   int n_cmp = 0;
   int n_err = 0;

   csr_intr_unit #(
      .NUM_EXT_IRQ(4),
      .EDGE_MASK  (4'b0100),
      .PRESCALE   (1),
      .MTVEC_RST  (32'h0000_0080)
   ) dut (
      .clk(clk), .rst(rst), .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_op(csr_op),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
      .pc_in(pc_in), .inst_valid(inst_valid), .is_mret(is_mret), .ext_irq(ext_irq),
      .intr_flag(intr_flag), .epc(epc), .t_intr(t_intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mtime with PRESCALE=1 is simply the number of clock edges seen out of reset.
   logic [63:0] mt;
   always @(posedge clk or posedge rst)
      if (rst) mt <= 64'd0;
      else     mt <= mt + 64'd1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      csr_wr = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
      tick();
      csr_wr = 1'b0;
   endtask

   task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string nm);
      csr_rd = 1'b1; csr_addr = a;
      #1;
      check(nm, csr_rdata, exp);
      csr_rd = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   // Register-level model for the randomized phase.
   logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
   logic [63:0] m_cmp;

   function automatic logic [31:0] op_apply(input logic [31:0] old, input logic [1:0] op,
                                            input logic [31:0] d);
      if (op == 2'd0) return d;
      if (op == 2'd1) return old | d;
      if (op == 2'd2) return old & ~d;
      return old;
   endfunction

   function automatic logic model_tip();
      return mt >= m_cmp;
   endfunction

   function automatic logic [31:0] model_rd(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return model_tip() ? 32'h80 : 32'h0;
         12'hC00: return mt[31:0];
         12'hC80: return mt[63:32];
         12'h7C0: return m_cmp[31:0];
         12'h7C1: return m_cmp[63:32];
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      logic [31:0] v;
      v = op_apply(model_rd(a), op, d);
      case (a)
         12'h300: m_mstatus = v & 32'h88;
         12'h304: m_mie     = v & 32'h000F_0080;
         12'h305: m_mtvec   = {v[31:2], 1'b0, v[1:0] == 2'b01};
         12'h341: m_mepc    = v & ~32'h3;
         12'h342: m_mcause  = v;
         12'h7C0: m_cmp[31:0]  = v;
         12'h7C1: m_cmp[63:32] = v;
         default: ;
      endcase
   endtask

   vec_t vecs[15];
   logic [11:0] addrs[11];

   initial begin
      vecs[0]  = '{2'd0, 12'h304, 32'h0000_0000, 32'h0000_0000};
      vecs[1]  = '{2'd1, 12'h304, 32'h0000_0080, 32'h0000_0080};
      vecs[2]  = '{2'd2, 12'h304, 32'h0000_0080, 32'h0000_0000};
      vecs[3]  = '{2'd0, 12'h304, 32'hFFFF_FFFF, 32'h000F_0080};
      vecs[4]  = '{2'd0, 12'h305, 32'h0000_0203, 32'h0000_0200};
      vecs[5]  = '{2'd0, 12'h305, 32'h0000_0102, 32'h0000_0100};
      vecs[6]  = '{2'd1, 12'h305, 32'h0000_0001, 32'h0000_0101};
      vecs[7]  = '{2'd0, 12'h341, 32'h0000_2003, 32'h0000_2000};
      vecs[8]  = '{2'd0, 12'h342, 32'h8000_0010, 32'h8000_0010};
      vecs[9]  = '{2'd0, 12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
      vecs[10] = '{2'd2, 12'h300, 32'h0000_0008, 32'h0000_0080};
      vecs[11] = '{2'd3, 12'h300, 32'h0000_00FF, 32'h0000_0080};
      vecs[12] = '{2'd0, 12'h123, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[13] = '{2'd0, 12'h7C1, 32'h1234_5678, 32'h1234_5678};
      vecs[14] = '{2'd0, 12'hC80, 32'hFFFF_FFFF, 32'h0000_0000};
      addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                12'hC00, 12'hC80, 12'h7C0, 12'h7C1, 12'h340};

      rst = 1'b1; csr_rd = 0; csr_wr = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
      pc_in = 0; inst_valid = 0; is_mret = 0; ext_irq = 0;
      tick(); tick();
      rst = 1'b0;
      check("rst_intr_flag", 32'(intr_flag), 0);
      check("rst_epc", epc, 0);
      rd_chk(12'h305, 32'h80, "rst_mtvec");
      rd_chk(12'h7C0, 32'hFFFF_FFFF, "rst_mtimecmp_lo");
      rd_chk(12'h300, 32'h0, "rst_mstatus");

      // Timer interrupt, direct mode.
      wr(2'd0, 12'h7C1, 32'h0);
      wr(2'd0, 12'h7C0, 32'd20);
      wr(2'd0, 12'h304, 32'h80);
      wr(2'd1, 12'h300, 32'h8);
      for (int i = 0; i < 100 && !t_intr; i++) tick();
      check("timer_rise", 32'(t_intr), 1);
      rd_chk(12'hC00, 32'd20, "timer_rise_mtime");
      pc_in = 32'h400; inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      check("timer_trap_flag", 32'(intr_flag), 1);
      check("timer_trap_epc", epc, 32'h80);
      rd_chk(12'h342, 32'h8000_0007, "timer_mcause");
      rd_chk(12'h300, 32'h80, "timer_mstatus");
      rd_chk(12'h341, 32'h400, "timer_mepc");
      tick();
      check("timer_flag_drop", 32'(intr_flag), 0);

      // mret with the timer still pending: RET first, trap only two edges later.
      wr(2'd0, 12'h341, 32'h2001);
      pc_in = 32'h404; inst_valid = 1'b1; is_mret = 1'b1;
      tick();
      is_mret = 1'b0;
      check("mret_flag", 32'(intr_flag), 1);
      check("mret_epc", epc, 32'h2000);
      rd_chk(12'h300, 32'h88, "mret_mstatus");
      tick();
      check("mret_no_same_trap", 32'(intr_flag), 0);
      tick();
      inst_valid = 1'b0;
      check("mret_later_trap", 32'(intr_flag), 1);
      check("mret_later_epc", epc, 32'h80);
      rd_chk(12'h341, 32'h404, "mret_later_mepc");
      tick();
      wr(2'd0, 12'h7C1, 32'hFFFF_FFFF);
      rd_chk(12'h344, 32'h0, "timer_cleared_mip");

      // Vectored edge IRQ on line 2; concurrent mie write must be dropped.
      wr(2'd0, 12'h305, 32'h101);
      wr(2'd0, 12'h304, 32'h0004_0000);
      wr(2'd1, 12'h300, 32'h8);
      ext_irq = 4'b0100;
      tick();
      ext_irq = 4'b0000;
      rd_chk(12'h344, 32'h0, "edge_mip_c1");
      tick();
      rd_chk(12'h344, 32'h0, "edge_mip_c2");
      tick();
      rd_chk(12'h344, 32'h0004_0000, "edge_mip_c3");
      tick(); tick();
      rd_chk(12'h344, 32'h0004_0000, "edge_mip_held");
      pc_in = 32'h500; inst_valid = 1'b1;
      csr_wr = 1'b1; csr_op = 2'd0; csr_addr = 12'h304; csr_wdata = 32'h0;
      tick();
      csr_wr = 1'b0; inst_valid = 1'b0;
      check("edge_trap_flag", 32'(intr_flag), 1);
      check("edge_trap_epc", epc, 32'h148);
      rd_chk(12'h342, 32'h8000_0012, "edge_mcause");
      rd_chk(12'h304, 32'h0004_0000, "edge_mie_kept");
      rd_chk(12'h344, 32'h0, "edge_latch_cleared");
      tick();
      ext_irq = 4'b0100;
      tick();
      ext_irq = 4'b0000;
      tick(); tick();
      rd_chk(12'h344, 32'h0004_0000, "edge_relatch");
      wr(2'd2, 12'h344, 32'h0004_0000);
      rd_chk(12'h344, 32'h0, "edge_csr_clear");

      // Priority: lines 1, 3 (level) and timer all pending.
      wr(2'd0, 12'h305, 32'h80);
      wr(2'd0, 12'h304, 32'h000A_0080);
      ext_irq = 4'b1010;
      wr(2'd0, 12'h7C1, 32'h0);
      wr(2'd0, 12'h7C0, 32'h0);
      tick(); tick(); tick();
      wr(2'd1, 12'h300, 32'h8);
      pc_in = 32'h600; inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      check("prio1_flag", 32'(intr_flag), 1);
      check("prio1_epc", epc, 32'h80);
      rd_chk(12'h342, 32'h8000_0011, "prio1_mcause");
      ext_irq = 4'b1000;
      tick(); tick(); tick(); tick();
      inst_valid = 1'b1; is_mret = 1'b1;
      tick();
      is_mret = 1'b0;
      check("prio_ret1_epc", epc, 32'h600);
      tick(); tick();
      inst_valid = 1'b0;
      check("prio2_flag", 32'(intr_flag), 1);
      rd_chk(12'h342, 32'h8000_0013, "prio2_mcause");
      ext_irq = 4'b0000;
      tick(); tick(); tick(); tick();
      inst_valid = 1'b1; is_mret = 1'b1;
      tick();
      is_mret = 1'b0;
      tick(); tick();
      inst_valid = 1'b0;
      check("prio3_flag", 32'(intr_flag), 1);
      rd_chk(12'h342, 32'h8000_0007, "prio3_mcause");
      tick();

      // Reset right after a trap decision.
      wr(2'd1, 12'h300, 32'h8);
      pc_in = 32'h700; inst_valid = 1'b1;
      tick();
      rst = 1'b1; inst_valid = 1'b0;
      #1;
      check("rstmid_flag", 32'(intr_flag), 0);
      check("rstmid_epc", epc, 0);
      rd_chk(12'h300, 32'h0, "rstmid_mstatus");
      rd_chk(12'h341, 32'h0, "rstmid_mepc");
      rd_chk(12'h342, 32'h0, "rstmid_mcause");
      tick();
      check("rstmid_flag_edge", 32'(intr_flag), 0);
      check("rstmid_t_intr", 32'(t_intr), 0);
      rd_chk(12'h304, 32'h0, "rstmid_mie");
      rd_chk(12'h305, 32'h80, "rstmid_mtvec");
      rd_chk(12'h7C1, 32'hFFFF_FFFF, "rstmid_mtimecmp_hi");
      rd_chk(12'hC00, 32'h0, "rstmid_mtime");
      rd_chk(12'h344, 32'h0, "rstmid_mip");
      rst = 1'b0;
      tick();
      check("rstmid_after_flag", 32'(intr_flag), 0);

      // CSR op vector table.
      for (int i = 0; i < 15; i++) begin
         wr(vecs[i].op, vecs[i].addr, vecs[i].wdata);
         rd_chk(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      end
      csr_rd = 1'b0; csr_addr = 12'h305;
      #1;
      check("rd_disabled", csr_rdata, 32'h0);

      // Randomized CSR traffic (no instruction boundaries, so no traps).
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_mstatus = 0; m_mie = 0; m_mtvec = 32'h80; m_mepc = 0; m_mcause = 0; m_cmp = '1;
      for (int k = 0; k < 300; k++) begin
         logic [11:0] a;
         logic [1:0]  op;
         logic [31:0] d;
         logic        do_wr;
         a     = addrs[$urandom_range(0, 10)];
         op    = 2'($urandom_range(0, 3));
         d     = $urandom;
         if ((a == 12'h7C0 || a == 12'h7C1) && $urandom_range(0, 1) == 1)
            d = $urandom_range(0, 400);
         do_wr = ($urandom_range(0, 3) != 0);
         check("rnd_t_intr", 32'(t_intr), 32'(model_tip()));
         if ($urandom_range(0, 7) == 0) begin
            csr_rd = 1'b0; csr_addr = a;
            #1;
            check("rnd_rd_off", csr_rdata, 32'h0);
         end else begin
            rd_chk(a, model_rd(a), $sformatf("rnd_%03h", a));
         end
         if (do_wr) begin
            wr(op, a, d);
            model_wr(a, op, d);
         end else begin
            tick();
         end
      end
      check("rnd_no_flag", 32'(intr_flag), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
